// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding imem request at a time, feeding a small FIFO toward decode.
// Build option: define FETCH_HALT_EN to stop fetching after a HALT opcode (6'b111111) is buffered.
module instr_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

`ifdef FETCH_HALT_EN
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;
    logic [1:0] state_q, state_d;
`else
    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    logic [0:0] state_q, state_d;
`endif

    logic [15:0]      pc_q, pc_d;
    logic [15:0]      req_pc_q, req_pc_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic             stale_q, stale_d;
    logic [2:0]       window_q, window_d;

    logic [31:0] slot_data [BUF_DEPTH];
    logic [15:0] slot_tag  [BUF_DEPTH];

    logic grant;
    logic xfer;
    logic stale_drop;
    logic rsp;
    logic buf_wr;

    always_comb begin
        imem_req = 1'b0;
        if (!reset && state_q == ST_FETCH && count_q < DEPTH_C && !redirect) begin
            imem_req = 1'b1;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = slot_data[rd_ptr_q];
    assign instr_pc    = slot_tag[rd_ptr_q];

    assign grant      = imem_req && imem_gnt;
    assign xfer       = instr_valid && instr_ready;
    // A response to a grant issued before reset may still arrive shortly after it.
    assign stale_drop = imem_rvalid && stale_q && (window_q != 3'd0);
    assign rsp        = imem_rvalid && !stale_drop && (state_q == ST_WAIT);
    assign buf_wr     = rsp && !discard_q && !redirect;

    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        if (grant) begin
            state_d  = ST_WAIT;
            pc_d     = pc_q + 16'd1;
            req_pc_d = pc_q;
        end
        if (rsp) begin
            state_d   = ST_FETCH;
            discard_d = 1'b0;
`ifdef FETCH_HALT_EN
            if (buf_wr && imem_rdata[31:26] == OP_HALT) begin
                state_d = ST_HALT;
            end
`endif
        end
        if (redirect) begin
            pc_d = redirect_pc;
            // A still-pending response must be swallowed before fetching resumes.
            if (state_q == ST_WAIT && !rsp) begin
                discard_d = 1'b1;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (xfer) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (buf_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({buf_wr, xfer})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        stale_d  = stale_q;
        window_d = window_q;
        if (reset) begin
            stale_d  = (stale_q || state_q == ST_WAIT) && !imem_rvalid;
            window_d = 3'd4;
        end else begin
            if (window_q != 3'd0) begin
                window_d = window_q - 3'd1;
            end
            if (stale_drop || window_q == 3'd0) begin
                stale_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            discard_q <= 1'b0;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            pc_q      <= pc_d;
            req_pc_q  <= req_pc_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
        end
        stale_q  <= stale_d;
        window_q <= window_d;
    end

    generate
        for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
            logic [31:0] data_q, data_d;
            logic [15:0] tag_q, tag_d;

            always_comb begin
                data_d = data_q;
                tag_d  = tag_q;
                if (buf_wr && wr_ptr_q == PTR_W'(gi)) begin
                    data_d = imem_rdata;
                    tag_d  = req_pc_q;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    data_q <= '0;
                    tag_q  <= '0;
                end else begin
                    data_q <= data_d;
                    tag_q  <= tag_d;
                end
            end

            assign slot_data[gi] = data_q;
            assign slot_tag[gi]  = tag_q;
        end
    endgenerate

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, word address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, default 2, instruction buffer entries; power of two, 2..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 imem_req  output  1  instruction memory read request, held until accepted.
REQ-006 imem_addr  output  16  word address of the current request; stable while imem_req is high.
REQ-007 imem_gnt  input  1  memory accepts the request in a cycle where imem_req and imem_gnt are both high.
REQ-008 imem_rvalid  input  1  read data valid; arrives at least 1 cycle after the grant, in order.
REQ-009 imem_rdata  input  32  instruction word, bits [31:26] opcode.
REQ-010 instr  output  32  instruction presented to decode.
REQ-011 instr_pc  output  16  word address of instr.
REQ-012 instr_valid  output  1  instr and instr_pc are valid.
REQ-013 instr_ready  input  1  decode accepts; a transfer occurs when instr_valid and instr_ready are both high.
REQ-014 redirect  input  1  one-cycle pulse that flushes fetch and restarts at redirect_pc.
REQ-015 redirect_pc  input  16  restart word address, sampled when redirect is high.

Function
REQ-016 States: FETCH (request may issue), WAIT (one request granted, data pending), HALT (see REQ-031).
- At most 1 outstanding request.
REQ-017 imem_req SHALL assert in FETCH only when (buffer occupancy + outstanding) < BUF_DEPTH and redirect is low.
- A grant moves the block FETCH->WAIT.
- imem_rvalid moves it WAIT->FETCH.
REQ-018 Fetch PC increments by 1 on each grant.
- 16'hFFFF wraps to 16'h0000.
REQ-019 The buffer is a FIFO of {imem_rdata, pc}.
- Written on a non-discarded imem_rvalid.
- Read on a transfer.
REQ-020 Timing:
- instr_valid is high exactly when the buffer is non-empty, driven from registers.
- Latency from imem_rvalid to instr_valid high is 1 cycle.
REQ-021 instr and instr_pc SHALL hold stable while instr_valid is high and instr_ready is low.
REQ-022 Full buffer with a transfer in the same cycle: a simultaneous write and read SHALL both take effect; occupancy is unchanged.
REQ-023 Redirect:
- Empties the buffer next cycle; instr_valid goes low.
- Fetch PC is set to redirect_pc.
- State returns to FETCH, or to WAIT-discard if a request is still outstanding.
REQ-024 WAIT-discard: the pending imem_rvalid SHALL be dropped, then the block returns to FETCH with no request issued that cycle.
REQ-025 redirect and imem_rvalid in the same cycle: the data SHALL be discarded.
REQ-026 redirect and a transfer in the same cycle: the transfer completes and redirect still flushes the remainder.
REQ-027 The first request after a redirect SHALL issue no earlier than the cycle after redirect.
- imem_addr equals redirect_pc.

Reset
REQ-028 Reset values:
- imem_req=0, instr_valid=0, instr=0, instr_pc=0.
- Buffer empty, outstanding=0, state FETCH.
- Fetch PC=RESET_PC.
REQ-029 Reset mid-operation SHALL abandon any outstanding request.
- An imem_rvalid in the first 4 cycles after reset deasserts SHALL be ignored if it belongs to a pre-reset grant.
- The memory model must not return pre-reset data later than that.
REQ-030 The first imem_req SHALL assert in the first cycle after reset deasserts, with imem_addr=RESET_PC.

Configuration
REQ-031 Macro FETCH_HALT_EN.
- Defined: a buffered word with opcode 6'b111111 (HALT) still transfers normally.
- On the cycle it is written into the buffer, the block enters HALT: no new requests, remaining buffer drains, and the block stays until redirect or reset.
- Not defined: HALT does not exist; opcode 6'b111111 is an ordinary instruction and the state encoding has only FETCH/WAIT.

Verification
REQ-032 Reset, imem grants every cycle, rvalid 1 cycle later, instr_ready=1 -> imem_addr 0,1,2,3 in consecutive requests; instr_pc 0,1,2,3 in order; one instruction per 2 cycles.
REQ-033 instr_ready=0 for 10 cycles -> exactly BUF_DEPTH (2) words buffered, imem_req low, instr held at PC 0; ready=1 -> PCs 0,1,2 delivered with no loss or duplicate.
REQ-034 redirect to 16'h0040 while WAIT -> returning data dropped, buffer flushed, next imem_addr=16'h0040, next instr_pc=16'h0040.
REQ-035 redirect_pc=16'hFFFE, free-running -> imem_addr sequence FFFE, FFFF, 0000, 0001.
REQ-036 FETCH_HALT_EN defined, word at PC 3 = 32'hFC000000 -> PCs 0..3 delivered, no requests after, instr_valid stays low; redirect to 16'h0010 resumes fetch at 0010; macro undefined -> PC 4 fetched.
